gerador_entradas: RTL and testbench
===================================

# gerador_entradas

Upstream stimulus stage for the four-input combinational circuit (inputs A, B, C, D; outputs X, Y, Z). It synchronizes and debounces raw board switches and a step button. It presents a registered 4-bit input word A..D either as a manual capture of the switches or as an automatic sweep of all 16 combinations, so every output combination of the circuit can be exercised on hardware. A `valid` pulse marks each new word for any downstream logger.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized cycles required before a debounced input changes (≥1).
- `AUTO_DIV`, default 8: cycles each word is held during a sweep (≥2).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sw` input 4: raw switches; `sw[3]`→A, `sw[2]`→B, `sw[1]`→C, `sw[0]`→D.
- `step_btn` input 1: raw push button, high = pressed.
- `mode` input 1: 0 = manual capture, 1 = sweep; sampled only on a step event.
- `A`, `B`, `C`, `D` output 1 each: registered word to the circuit; A = MSB.
- `valid` output 1: one-cycle pulse when A..D take a new word.
- `sweep_done` output 1: level, high while in DONE.

## Operation
- **Input conditioning.** Each of `sw[3:0]` and `step_btn` passes through a 2-flop synchronizer, then a per-bit debouncer.
  - Debounced bit changes only after the synchronized bit differs from it for `DEB_CYCLES` consecutive cycles.
  - Any glitch back to the debounced value resets that bit's counter.
- **Step event.** One-cycle pulse on the 0→1 edge of debounced `step_btn`. Release generates nothing.
- **States.** IDLE, HOLD, SWEEP, DONE. Reset state is IDLE.
- **IDLE, HOLD, DONE on a step event:**
  - `mode`=0: load debounced `sw` into A..D, pulse `valid`, go to HOLD.
  - `mode`=1: load 0000, pulse `valid`, clear the divider, go to SWEEP.
- **SWEEP:**
  - Divider counts 0..`AUTO_DIV`-1. On terminal count with word < 1111: increment word, pulse `valid`, restart divider.
  - On terminal count with word = 1111: go to DONE. No `valid` pulse; A..D stay 1111.
  - Step event in SWEEP aborts the sweep: go to HOLD with the current word, no `valid` pulse.
  - `mode` changes during SWEEP are ignored.
- **HOLD / DONE.** A..D are frozen; switch changes have no effect until the next step event.
- **Reset.** Asynchronous; allowed at any time, including mid-sweep or mid-debounce.
  - A..D = 0000, `valid` = 0, `sweep_done` = 0, state IDLE.
  - Divider, debounce counters and synchronizers are cleared. Debounced values = 0.

## Timing
- A raw change is stable before edge k. It appears at the synchronizer output after edge k+1.
- The debounced value updates at edge k+1+`DEB_CYCLES`. The step event is high during the following cycle.
- A..D and `valid` update at edge k+2+`DEB_CYCLES`. Press-to-word latency is therefore `DEB_CYCLES`+2 cycles.
- All outputs are registered. `valid` is coincident with the cycle in which the new word first appears.
- In SWEEP each word is held exactly `AUTO_DIV` cycles. A full sweep lasts 16×`AUTO_DIV` cycles from the first 0000 to DONE entry.
- `sweep_done` rises on the edge after the final divider terminal count.
- A step event in the same cycle as a SWEEP terminal count takes priority: abort to HOLD, word not incremented.

## Configuration
- `GERADOR_WRAP_EN` defined: SWEEP never enters DONE. After 1111 the word wraps to 0000 with a `valid` pulse, and the sweep repeats until a step event. `sweep_done` is tied 0.
- `GERADOR_WRAP_EN` undefined: sweep stops in DONE as described above.

## Test plan
All cases use `DEB_CYCLES`=4, `AUTO_DIV`=8.
- **Reset.** Assert `rst` mid-cycle → A..D=0000, `valid`=0, `sweep_done`=0 immediately, without waiting for a clock edge.
- **Manual capture.** `sw`=1011, `mode`=0, press `step_btn` held 10 cycles → A..D=1,0,1,1 exactly 6 cycles after the press, with a single `valid` pulse. Later `sw`=0000 without a press → A..D unchanged.
- **Debounce.** `step_btn` toggled high 3 cycles then low → no event, A..D unchanged. High 4 cycles → event.
- **Full sweep.** `mode`=1 press → 16 `valid` pulses 8 cycles apart, words 0000..1111 in order. `sweep_done`=1 128 cycles after the 0000 word; A..D stay 1111.
- **Abort.** Press during word 0101 of a sweep → state HOLD, A..D remain 0101, no further `valid` pulses.
- **Wrap** (`GERADOR_WRAP_EN` defined). Run the sweep 20 words → word 0000 follows 1111 with a `valid` pulse; `sweep_done` never rises.

Source files
------------

// File: rtl/gerador_entradas.sv
// Stimulus generator for a 4-input combinational circuit: synchronizes/debounces switches
// and a step button, then presents A..D as a manual capture or a 16-word sweep.
// Optional feature: define GERADOR_WRAP_EN to make the sweep wrap forever instead of stopping in DONE.
module gerador_entradas #(
  parameter int DEB_CYCLES = 4,
  parameter int AUTO_DIV   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       step_btn,
  input  logic       mode,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       valid,
  output logic       sweep_done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam int DW = $clog2(AUTO_DIV);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

  // Bit 4 carries the step button, bits 3:0 the switches.
  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    deb;
  logic [CW-1:0] cnt [5];
  logic          step_q;
  logic          step_ev;

  state_t        state;
  logic [3:0]    word;
  logic [DW-1:0] div;

  assign raw = {step_btn, sw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A bit flips only after disagreeing with its debounced value for DEB_CYCLES edges in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb    <= '0;
      step_q <= 1'b0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      step_q <= deb[4];
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign step_ev = deb[4] & ~step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      valid      <= 1'b0;
      sweep_done <= 1'b0;
      div        <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        SWEEP: begin
          // A step event outranks a coincident terminal count.
          if (step_ev) begin
            state <= HOLD;
          end else if (div == DIV_LAST) begin
`ifdef GERADOR_WRAP_EN
            word  <= word + 4'd1;
            valid <= 1'b1;
            div   <= '0;
`else
            if (word != 4'hF) begin
              word  <= word + 4'd1;
              valid <= 1'b1;
              div   <= '0;
            end else begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end
`endif
          end else begin
            div <= div + 1'b1;
          end
        end
        default: begin
          if (step_ev) begin
            valid      <= 1'b1;
            sweep_done <= 1'b0;
            if (mode) begin
              word  <= 4'h0;
              div   <= '0;
              state <= SWEEP;
            end else begin
              word  <= deb[3:0];
              state <= HOLD;
            end
          end
        end
      endcase
    end
  end

  assign A         = word[3];
  assign B         = word[2];
  assign C         = word[1];
  assign D         = word[0];
  assign state_dbg = state;

endmodule

// File: tb/tb_gerador_entradas.sv
// Directed bench for gerador_entradas (DEB_CYCLES=4, AUTO_DIV=8): capture, debounce, sweep,
// priority abort and asynchronous reset; every valid pulse is checked against an expected-word queue.
module tb_gerador_entradas;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_SWEEP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       step_btn;
  logic       mode;
  logic       A, B, C, D;
  logic       valid;
  logic       sweep_done;
  logic [1:0] state_dbg;
  logic [3:0] word;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  assign word = {A, B, C, D};

  gerador_entradas #(.DEB_CYCLES(4), .AUTO_DIV(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .step_btn   (step_btn),
    .mode       (mode),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .valid      (valid),
    .sweep_done (sweep_done),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the next expected word
  always @(negedge clk) begin
    if (rst === 1'b0 && valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_valid: observed word %0h expected no valid", word);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        assert (word === e)
        else begin
          n_err++;
          $error("FAIL valid_word: observed %0h expected %0h", word, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sw = 4'h0; step_btn = 1'b0; mode = 1'b0;
    tick();
    check("rst_word",  8'(word), 8'h0);
    check("rst_valid", 8'(valid), 8'h0);
    check("rst_state", 8'(state_dbg), 8'(S_IDLE));
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("idle_state", 8'(state_dbg), 8'(S_IDLE));

    // Manual capture of 1011, button held 10 cycles
    sw = 4'b1011;
    repeat (10) tick();
    exp_q.push_back(4'b1011);
    step_btn = 1'b1;
    repeat (6) tick();
    check("cap_early_word",  8'(word), 8'h0);
    check("cap_early_valid", 8'(valid), 8'h0);
    tick();
    check("cap_word",  8'(word), 8'hB);
    check("cap_valid", 8'(valid), 8'h1);
    check("cap_state", 8'(state_dbg), 8'(S_HOLD));
    repeat (3) tick();
    step_btn = 1'b0;
    repeat (12) tick();

    // Switches change with no press: word frozen
    sw = 4'b0000;
    repeat (12) tick();
    check("hold_frozen", 8'(word), 8'hB);
    check("hold_state",  8'(state_dbg), 8'(S_HOLD));

    // 3-cycle press is filtered out
    step_btn = 1'b1;
    repeat (3) tick();
    step_btn = 1'b0;
    repeat (12) tick();
    check("deb3_word", 8'(word), 8'hB);

    // 4-cycle press is accepted and captures the new switches
    exp_q.push_back(4'b0000);
    step_btn = 1'b1;
    repeat (4) tick();
    step_btn = 1'b0;
    repeat (2) tick();
    check("deb4_early", 8'(word), 8'hB);
    tick();
    check("deb4_word",  8'(word), 8'h0);
    check("deb4_valid", 8'(valid), 8'h1);
    repeat (12) tick();

    // Full sweep
    for (int w = 0; w < 16; w++) exp_q.push_back(4'(w));
`ifdef GERADOR_WRAP_EN
    for (int w = 0; w < 4; w++) exp_q.push_back(4'(w));
`endif
    mode = 1'b1;
    step_btn = 1'b1;
    repeat (5) tick();
    step_btn = 1'b0;
    tick();
    check("sw0_early", 8'(valid), 8'h0);
    tick();
    check("sw0_word",  8'(word), 8'h0);
    check("sw0_valid", 8'(valid), 8'h1);
    check("sw0_state", 8'(state_dbg), 8'(S_SWEEP));
    for (int w = 1; w < 16; w++) begin
      if (w == 8) mode = 1'b0;
      repeat (7) tick();
      check("sw_gap_valid", 8'(valid), 8'h0);
      check("sw_gap_word",  8'(word), 8'(w - 1));
      tick();
      check("sw_step_word",  8'(word), 8'(w));
      check("sw_step_valid", 8'(valid), 8'h1);
    end
    repeat (7) tick();
    check("done_early", 8'(sweep_done), 8'h0);
    tick();
`ifdef GERADOR_WRAP_EN
    check("wrap_word",  8'(word), 8'h0);
    check("wrap_valid", 8'(valid), 8'h1);
    check("wrap_done",  8'(sweep_done), 8'h0);
    for (int w = 1; w < 4; w++) begin
      repeat (8) tick();
      check("wrap_step_word", 8'(word), 8'(w));
      check("wrap_done_low",  8'(sweep_done), 8'h0);
    end
`else
    check("done_rise",  8'(sweep_done), 8'h1);
    check("done_word",  8'(word), 8'hF);
    check("done_valid", 8'(valid), 8'h0);
    repeat (20) tick();
    check("done_hold_word",  8'(word), 8'hF);
    check("done_hold_state", 8'(state_dbg), 8'(S_DONE));
    check("done_hold_level", 8'(sweep_done), 8'h1);
`endif

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("arst_word",  8'(word), 8'h0);
    check("arst_valid", 8'(valid), 8'h0);
    check("arst_done",  8'(sweep_done), 8'h0);
    check("arst_state", 8'(state_dbg), 8'(S_IDLE));
    repeat (2) tick();
    rst = 1'b0;

    // Abort on the terminal-count cycle of word 0101
    sw = 4'b1111;
    mode = 1'b1;
    repeat (10) tick();
    for (int w = 0; w < 6; w++) exp_q.push_back(4'(w));
    step_btn = 1'b1;
    repeat (5) tick();
    step_btn = 1'b0;
    repeat (2) tick();
    check("ab0_word",  8'(word), 8'h0);
    check("ab0_state", 8'(state_dbg), 8'(S_SWEEP));
    mode = 1'b0;
    for (int w = 1; w < 6; w++) begin
      repeat (8) tick();
      check("ab_step_word", 8'(word), 8'(w));
    end
    tick();
    step_btn = 1'b1;
    repeat (5) tick();
    step_btn = 1'b0;
    check("ab_pre_state", 8'(state_dbg), 8'(S_SWEEP));
    repeat (20) tick();
    check("ab_word",  8'(word), 8'h5);
    check("ab_state", 8'(state_dbg), 8'(S_HOLD));
    check("ab_done",  8'(sweep_done), 8'h0);

    check("exp_q_empty", 8'(exp_q.size()), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
